// File: rtl/game_state_fsm.sv
// Obstacle game controller: menu/play/won/lost flow, lives with a
// post-hit invulnerability window, and a three-phase speed schedule.
module game_state_fsm #(
   parameter logic [10:0] PHASE1_T = 11'd300,
   parameter logic [10:0] PHASE2_T = 11'd600,
   parameter logic [10:0] WIN_T    = 11'd900,
   parameter logic [1:0]  LIVES    = 2'd3,
   parameter logic [5:0]  INVULN   = 6'd30,
   parameter logic [7:0]  HOLD     = 8'd120
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_btn,
   input  logic        collision,
   input  logic [10:0] game_time,
   output logic        menuScreen,
   output logic        playerWon,
   output logic        playerLost,
   output logic        reset_obj_count,
   output logic [1:0]  phase,
   output logic [1:0]  lives
);

   typedef enum logic [1:0] {
      S_MENU,
      S_PLAY,
      S_WON,
      S_LOST
   } state_e;

   state_e      state_q, state_d;
   logic        start_q;
   logic [1:0]  lives_q, lives_d;
   logic [1:0]  phase_q, phase_d;
   logic [5:0]  inv_q, inv_d;
   logic [7:0]  hold_q, hold_d;
   logic        roc_q, roc_d;
   logic        menu_q, menu_d;
   logic        won_q, won_d;
   logic        lost_q, lost_d;

   logic        start_rise;
   logic        hit;
   logic        fatal;
   logic        win;
   logic        adv;

   assign start_rise = start_btn & ~start_q;

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      phase_d = phase_q;
      inv_d   = inv_q;
      hold_d  = hold_q;
      roc_d   = 1'b0;
      hit     = 1'b0;
      fatal   = 1'b0;
      win     = 1'b0;
      adv     = 1'b0;

      unique case (state_q)
         S_MENU: begin
            if (start_rise) begin
               state_d = S_PLAY;
               lives_d = LIVES;
               phase_d = 2'd0;
               inv_d   = '0;
            end
         end
         S_PLAY: begin
            hit   = collision && (inv_q == '0) && (lives_q != '0);
            fatal = hit && (lives_q == 2'd1);
            win   = (game_time >= WIN_T);
            adv   = ((phase_q == 2'd0) && (game_time == PHASE1_T)) ||
                    ((phase_q == 2'd1) && (game_time == PHASE2_T));
            if (fatal) begin
               lives_d = 2'd0;
               state_d = S_LOST;
               hold_d  = '0;
            end else begin
               if (hit) begin
                  lives_d = lives_q - 2'd1;
                  inv_d   = INVULN;
               end else if (inv_q != '0) begin
                  inv_d = inv_q - 6'd1;
               end
               // A win ends the level, so no speed change on that cycle
               if (win) begin
                  state_d = S_WON;
                  hold_d  = '0;
               end else if (adv) begin
                  phase_d = phase_q + 2'd1;
                  roc_d   = 1'b1;
               end
            end
         end
         S_WON, S_LOST: begin
            if (start_rise || (hold_q == HOLD - 8'd1)) begin
               state_d = S_MENU;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = S_MENU;
         end
      endcase

      menu_d = (state_d == S_MENU);
      won_d  = (state_d == S_WON);
      lost_d = (state_d == S_LOST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_MENU;
         start_q <= 1'b0;
         lives_q <= LIVES;
         phase_q <= 2'd0;
         inv_q   <= '0;
         hold_q  <= '0;
         roc_q   <= 1'b0;
         menu_q  <= 1'b1;
         won_q   <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_btn;
         lives_q <= lives_d;
         phase_q <= phase_d;
         inv_q   <= inv_d;
         hold_q  <= hold_d;
         roc_q   <= roc_d;
         menu_q  <= menu_d;
         won_q   <= won_d;
         lost_q  <= lost_d;
      end
   end

   assign menuScreen      = menu_q;
   assign playerWon       = won_q;
   assign playerLost      = lost_q;
   assign reset_obj_count = roc_q;
   assign phase           = phase_q;
   assign lives           = lives_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Scoreboard bench for game_state_fsm: a cycle model predicts the
// registered outputs, which are queued and compared after each edge.
module tb_game_state_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_btn;
   logic        collision;
   logic [10:0] game_time;
   logic        menuScreen;
   logic        playerWon;
   logic        playerLost;
   logic        reset_obj_count;
   logic [1:0]  phase;
   logic [1:0]  lives;

   always #5 clk = ~clk;

   game_state_fsm dut (
      .clk             (clk),
      .reset           (reset),
      .start_btn       (start_btn),
      .collision       (collision),
      .game_time       (game_time),
      .menuScreen      (menuScreen),
      .playerWon       (playerWon),
      .playerLost      (playerLost),
      .reset_obj_count (reset_obj_count),
      .phase           (phase),
      .lives           (lives)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   // model state: 0 menu, 1 play, 2 won, 3 lost
   int       m_st = 0;
   logic     m_sq = 1'b0;
   int       m_lives = 3;
   int       m_phase = 0;
   int       m_inv = 0;
   int       m_hold = 0;
   logic     m_roc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic model(input logic rst, input logic s, input logic c,
                        input int g);
      logic rise;
      logic hit;
      m_roc = 1'b0;
      if (rst) begin
         m_st = 0; m_sq = 1'b0; m_lives = 3; m_phase = 0;
         m_inv = 0; m_hold = 0;
         return;
      end
      rise = s && !m_sq;
      m_sq = s;
      if (m_st == 0) begin
         if (rise) begin
            m_st = 1; m_lives = 3; m_phase = 0; m_inv = 0;
         end
      end else if (m_st == 1) begin
         hit = c && (m_inv == 0);
         if (hit && m_lives == 1) begin
            m_lives = 0; m_st = 3; m_hold = 0;
         end else begin
            if (hit) begin
               m_lives = m_lives - 1;
               m_inv = 30;
            end else if (m_inv > 0) begin
               m_inv = m_inv - 1;
            end
            if (g >= 900) begin
               m_st = 2; m_hold = 0;
            end else if (m_phase == 0 && g == 300) begin
               m_phase = 1; m_roc = 1'b1;
            end else if (m_phase == 1 && g == 600) begin
               m_phase = 2; m_roc = 1'b1;
            end
         end
      end else begin
         if (rise || m_hold == 119) begin
            m_st = 0; m_hold = 0;
         end else begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   task automatic step(input logic rst, input logic s, input logic c,
                       input int g);
      logic [7:0] e;
      reset = rst; start_btn = s; collision = c; game_time = 11'(g);
      model(rst, s, c, g);
      e = {m_st == 0, m_st == 2, m_st == 3, m_roc,
           2'(m_phase), 2'(m_lives)};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      chk("outs", {menuScreen, playerWon, playerLost, reset_obj_count,
                   phase, lives}, exp_q.pop_front());
   endtask

   initial begin
      int falls;
      int pulses;
      int won_cyc;
      int g;
      logic pm;

      reset = 1'b1; start_btn = 1'b0; collision = 1'b0; game_time = '0;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_vec", {menuScreen, playerWon, playerLost, reset_obj_count,
                      phase, lives}, 8'b1000_0011);
      step(0, 0, 0, 0);

      // start held: one entry only
      falls = 0;
      pm = menuScreen;
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 0);
         if (i == 0) chk("menu_fall1", menuScreen, 0);
         if (pm && !menuScreen) falls++;
         pm = menuScreen;
      end
      chk("one_entry", falls, 1);
      chk("start_lives", lives, 3);

      // clean ramp to win
      pulses = 0;
      for (int t = 0; t <= 905; t++) begin
         step(0, 0, 0, t);
         if (reset_obj_count) pulses++;
      end
      chk("roc_pulses", pulses, 2);
      chk("won", playerWon, 1);
      chk("phase2", phase, 2);
      won_cyc = 6;
      for (int i = 0; i < 130; i++) begin
         step(0, 0, 0, 0);
         if (playerWon) won_cyc++;
      end
      chk("won_len", won_cyc, 120);
      chk("back_menu", menuScreen, 1);

      // continuous collision drains lives
      step(0, 1, 0, 0);
      for (int i = 0; i < 100; i++) step(0, 0, 1, i);
      chk("lost", playerLost, 1);
      chk("lives0", lives, 0);
      for (int i = 0; i < 100; i++) step(0, 0, 1, 0);
      chk("lost_menu", menuScreen, 1);

      // fatal hit coincident with win
      step(0, 1, 0, 0);
      for (int t = 0; t <= 900; t++)
         step(0, 0, (t == 100 || t == 200 || t == 900), t);
      chk("tie_lost", playerLost, 1);
      chk("tie_nowon", playerWon, 0);

      // early exit from LOST on a start rise at hold 10
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("early_menu", menuScreen, 1);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("fresh_lives", lives, 3);
      chk("fresh_phase", phase, 0);

      // reset mid-level with phase 2, lives 1
      for (int t = 0; t <= 650; t++)
         step(0, 0, (t == 10 || t == 50), t);
      chk("pre_phase", phase, 2);
      chk("pre_lives", lives, 1);
      step(1, 0, 0, 651);
      chk("mid_rst", {menuScreen, playerWon, playerLost, reset_obj_count,
                      phase, lives}, 8'b1000_0011);

      // random play
      g = 0;
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 999) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0), g);
         g = (m_st == 1) ? ((g < 1000) ? g + 1 : g) : 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/game_state_fsm.md
# game_state_fsm

Top-level game controller for the obstacle game; sits directly upstream of the obstacle position/level-time counter. Owns the MENU → PLAY → WON/LOST → MENU flow, tracks player lives with a post-hit invulnerability window, and divides a level into three speed phases by comparing the counter's returned `game_time` against thresholds. Drives the counter's `menuScreen`, `playerWon`, `playerLost` and `reset_obj_count` controls and exports `phase` and `lives` to the renderer.

## Interface
Parameters:
- `PHASE1_T`, 11'd300: `game_time` value at which phase 0 → 1.
- `PHASE2_T`, 11'd600: `game_time` value at which phase 1 → 2.
- `WIN_T`, 11'd900: `game_time` value at or above which the level is won.
- `LIVES`, 2'd3: lives at level start (1..3).
- `INVULN`, 6'd30: cycles of collision immunity after a hit.
- `HOLD`, 8'd120: cycles spent in WON/LOST before auto-return to MENU.

Ports:
- `clk` in 1: single clock, same clock as the counter.
- `reset` in 1: synchronous, active-high.
- `start_btn` in 1: debounced start button level, synchronous to `clk`.
- `collision` in 1: player/obstacle overlap this cycle.
- `game_time` in 11: level time from the counter.
- `menuScreen` out 1: high in MENU.
- `playerWon` out 1: high in WON.
- `playerLost` out 1: high in LOST.
- `reset_obj_count` out 1: one-cycle pulse on each phase advance.
- `phase` out 2: 0, 1, 2; obstacle speed select.
- `lives` out 2: remaining lives.

## Operation
- States: MENU, PLAY, WON, LOST. All outputs are registered.
- Start edge: `start_q` registers `start_btn`; `start_rise = start_btn & ~start_q`. Level-held button never re-triggers.
- MENU: `menuScreen`=1. On `start_rise`, go to PLAY; load `lives`=LIVES, `phase`=0, clear invuln timer.
- PLAY, evaluated each cycle in priority order:
  1. Hit: `collision` & invuln==0. If `lives`==1, set `lives`=0 and go to LOST. Otherwise decrement `lives` and load invuln=INVULN.
  2. Win: `game_time` ≥ WIN_T and no fatal hit this cycle; go to WON.
  3. Phase advance:
     - `phase`==0 & `game_time`==PHASE1_T: `phase`=1.
     - `phase`==1 & `game_time`==PHASE2_T: `phase`=2.
     - Either advance pulses `reset_obj_count` for exactly one cycle. Phase never exceeds 2 and never decrements within a level.
  4. Invuln timer decrements to 0 and saturates. Collisions while it is nonzero are ignored.
- WON / LOST:
  - Assert the matching flag; `phase` and `lives` hold their values.
  - Hold counter counts from 0. At HOLD−1, or on `start_rise`, whichever comes first, go to MENU.
- Fatal hit and win in the same cycle: LOST wins. Non-fatal hit and win in the same cycle: decrement `lives`, then go to WON.
- Phase advance and fatal hit in the same cycle: no `reset_obj_count` pulse.
- `collision` is ignored outside PLAY. `start_rise` is ignored in PLAY.

## Timing
- Reset values, applied on the first `clk` edge with `reset`=1: state=MENU, `menuScreen`=1, `playerWon`=0, `playerLost`=0, `reset_obj_count`=0, `phase`=0, `lives`=LIVES, `start_q`=0, timers=0.
- `reset` mid-level overrides everything; the next state is MENU.
- Latency: `start_btn` rise at edge N is seen at edge N+1; `menuScreen` falls after edge N+1. The counter's `game_time` then counts from 0.
- `collision` sampled at edge N updates `lives` and state at edge N; outputs are visible after that edge.
- `reset_obj_count` is high for the cycle after the edge at which `game_time`==threshold is sampled. It is never high two cycles in a row.
- WON/LOST lasts exactly HOLD cycles absent `start_rise`.
- Widths:
  - `game_time` comparisons are unsigned 11-bit.
  - Invuln timer is 6-bit; hold counter is 8-bit.
  - `lives` never wraps below 0.

## Test plan
- Reset then `start_btn` held high 10 cycles → exactly one MENU→PLAY; `menuScreen` falls 1 cycle after the rise; `lives`=3, `phase`=0.
- Ramp `game_time` 0..900 in PLAY, no collisions → `reset_obj_count` pulses once at 300 and once at 600; `phase` goes 0→1→2; `playerWon`=1 after 900; back to MENU after 120 cycles.
- `collision` held high continuously → `lives` 3→2, then 2→1 after 30 cycles, then 1→0 with `playerLost`=1 after 30 more cycles.
- `collision` with `lives`=1 in the same cycle as `game_time`=900 → LOST, `playerWon` stays 0.
- LOST state plus a `start_btn` rise at hold cycle 10 → MENU on the next cycle; a fresh start reloads `lives`=3, `phase`=0.
- Assert `reset` during PLAY with `phase`=2, `lives`=1 → next cycle MENU, all outputs at reset values.
